// File: rtl/ram_arbiter.sv
// Purpose: arbitrates video reads and fill reads/writes onto one memory controller port, with fill starvation guard.
// Latency: grant is combinational in the IDLE cycle; completion is forwarded combinationally on mem_ready, next grant 1 cycle later.
// Backpressure: one access in flight; requesters hold their level request until ack, and a BUSY timer recovers a missing mem_ready.
module ram_arbiter #(
    parameter int AW          = 25,
    parameter int DW          = 16,
    parameter int INIT_CYCLES = 5000000,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT     = 63
) (
    input  logic          clk_ram,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [DW-1:0] vid_dout,
    input  logic          fill_req,
    input  logic          fill_we,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_din,
    input  logic [1:0]    fill_wtbt,
    output logic          fill_ack,
    output logic          fill_valid,
    output logic [DW-1:0] fill_dout,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [1:0]    mem_wtbt,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    output logic          ready,
    output logic          timeout_err
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY} state_t;

    localparam int IW = $clog2(INIT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] init_cnt_q;
    logic [2:0]    starve_q;
    logic          owner_fill_q;
    logic          owner_we_q;
    logic [5:0]    timer_q;
    logic          err_q;
    logic [DW-1:0] vid_dat_q;
    logic [DW-1:0] fill_dat_q;
    logic          grant_vid;
    logic          grant_fill;
    logic          done;
    logic          tmo;

    // Next state and single-cycle strobes; everything is suppressed while reset is high
    always_comb begin
        state_d    = state_q;
        grant_vid  = 1'b0;
        grant_fill = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // Video wins unless fill has been passed over STARVE_MAX times in a row
                if (fill_req && (!vid_req || starve_q == 3'(STARVE_MAX))) begin
                    grant_fill = 1'b1;
                    state_d    = ST_BUSY;
                end else if (vid_req) begin
                    grant_vid = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == 6'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (reset) begin
            grant_vid  = 1'b0;
            grant_fill = 1'b0;
            done       = 1'b0;
            tmo        = 1'b0;
        end
    end

    // Control state: FSM, init counter, starvation counter, owner, busy timer, sticky error
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            starve_q     <= 3'd0;
            owner_fill_q <= 1'b0;
            owner_we_q   <= 1'b0;
            timer_q      <= 6'd0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + IW'(1);
            if (grant_fill) begin
                starve_q <= 3'd0;
            end else if (grant_vid) begin
                if (!fill_req)             starve_q <= 3'd0;
                else if (starve_q != 3'd7) starve_q <= starve_q + 3'd1;
            end
            if (grant_vid || grant_fill) begin
                owner_fill_q <= grant_fill;
                owner_we_q   <= grant_fill & fill_we;
                timer_q      <= 6'd0;
            end else if (state_q == ST_BUSY) begin
                timer_q <= timer_q + 6'd1;
            end
            if (tmo) err_q <= 1'b1;
        end
    end

    // Read data holding registers so each dout keeps its last completed read
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            vid_dat_q  <= '0;
            fill_dat_q <= '0;
        end else begin
            if (vid_valid)                 vid_dat_q  <= mem_dout;
            if (fill_valid && !owner_we_q) fill_dat_q <= mem_dout;
        end
    end

    assign vid_ack     = grant_vid;
    assign fill_ack    = grant_fill;
    assign mem_rd      = grant_vid | (grant_fill & ~fill_we);
    assign mem_we      = grant_fill & fill_we;
    assign mem_addr    = grant_vid ? vid_addr : (grant_fill ? fill_addr : '0);
    assign mem_din     = grant_fill ? fill_din : '0;
    assign mem_wtbt    = grant_vid ? 2'b11 : (grant_fill ? fill_wtbt : 2'b00);
    assign vid_valid   = done & ~owner_fill_q;
    assign fill_valid  = done & owner_fill_q;
    assign vid_dout    = reset ? '0 : (vid_valid ? mem_dout : vid_dat_q);
    assign fill_dout   = reset ? '0 : ((fill_valid && !owner_we_q) ? mem_dout : fill_dat_q);
    assign ready       = (state_q != ST_INIT) && !reset;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose: directed self-checking bench for ram_arbiter with a grant/read-data scoreboard.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: the bench plays the memory controller, answering each grant after a chosen delay.
module tb_ram_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;

    typedef struct packed {
        logic          fill;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [1:0]    wtbt;
    } gnt_t;

    logic          clk_ram = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_valid;
    logic [DW-1:0] vid_dout;
    logic          fill_req;
    logic          fill_we;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_din;
    logic [1:0]    fill_wtbt;
    logic          fill_ack;
    logic          fill_valid;
    logic [DW-1:0] fill_dout;
    logic          mem_rd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [1:0]    mem_wtbt;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          ready;
    logic          timeout_err;

    int            checks = 0;
    int            errors = 0;
    gnt_t          gq[$];
    logic [DW-1:0] rq[$];
    logic [DW-1:0] last_vid  = '0;
    logic [DW-1:0] last_fill = '0;

    ram_arbiter #(
        .AW(AW), .DW(DW), .INIT_CYCLES(8), .STARVE_MAX(4), .TIMEOUT(63)
    ) dut (
        .clk_ram(clk_ram), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_dout(vid_dout),
        .fill_req(fill_req), .fill_we(fill_we), .fill_addr(fill_addr),
        .fill_din(fill_din), .fill_wtbt(fill_wtbt), .fill_ack(fill_ack),
        .fill_valid(fill_valid), .fill_dout(fill_dout),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wtbt(mem_wtbt), .mem_dout(mem_dout),
        .mem_ready(mem_ready), .ready(ready), .timeout_err(timeout_err)
    );

    always #5 clk_ram = ~clk_ram;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_ram);
        @(negedge clk_ram);
    endtask

    function automatic gnt_t mk(input logic f, input logic w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [1:0] b);
        gnt_t g;
        g.fill = f; g.we = w; g.addr = a; g.din = d; g.wtbt = b;
        return g;
    endfunction

    task automatic drive_vid(input logic [AW-1:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
        gq.push_back(mk(1'b0, 1'b0, a, '0, 2'b11));
    endtask

    task automatic drive_fill(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [1:0] b);
        fill_req  = 1'b1;
        fill_we   = w;
        fill_addr = a;
        fill_din  = d;
        fill_wtbt = b;
        gq.push_back(mk(1'b1, w, a, d, b));
    endtask

    task automatic check_grant();
        gnt_t g;
        chk("grant_queue_nonempty", {31'd0, gq.size() != 0}, 32'd1);
        if (gq.size() == 0) return;
        g = gq.pop_front();
        chk("vid_ack",  vid_ack,  !g.fill);
        chk("fill_ack", fill_ack, g.fill);
        chk("mem_rd",   mem_rd,   !g.we);
        chk("mem_we",   mem_we,   g.we);
        chk("mem_addr", mem_addr, g.addr);
        chk("mem_din",  mem_din,  g.din);
        chk("mem_wtbt", mem_wtbt, g.wtbt);
    endtask

    // From a grant cycle: answer after lat cycles with data, check the completion, end in the next IDLE cycle.
    task automatic complete(input logic fill, input logic we, input int lat,
                            input logic [DW-1:0] data, input logic drop);
        logic [DW-1:0] exp;
        for (int i = 1; i <= lat; i++) begin
            nxt();
            if (i == 1 && drop) begin vid_req = 1'b0; fill_req = 1'b0; end
            if (i == lat) begin
                mem_ready = 1'b1;
                mem_dout  = data;
                if (!we) rq.push_back(data);
            end
            #1;
            chk("busy_mem_rd", mem_rd, 1'b0);
            chk("busy_mem_we", mem_we, 1'b0);
            if (i < lat) begin
                chk("busy_vid_valid",  vid_valid,  1'b0);
                chk("busy_fill_valid", fill_valid, 1'b0);
            end
        end
        chk("done_vid_valid",  vid_valid,  !fill);
        chk("done_fill_valid", fill_valid, fill);
        exp = last_fill;
        if (!we) begin
            chk("read_queue_nonempty", {31'd0, rq.size() != 0}, 32'd1);
            if (rq.size() != 0) exp = rq.pop_front();
        end
        if (fill) begin
            chk("fill_dout", fill_dout, exp);
            last_fill = exp;
            chk("vid_dout_idle", vid_dout, last_vid);
        end else begin
            chk("vid_dout", vid_dout, exp);
            last_vid = exp;
            chk("fill_dout_idle", fill_dout, last_fill);
        end
        nxt();
        mem_ready = 1'b0;
        mem_dout  = 16'hDEAD;
        #1;
        chk("vid_dout_hold",  vid_dout,  last_vid);
        chk("fill_dout_hold", fill_dout, last_fill);
    endtask

    // Called on the falling edge where reset has just been released.
    task automatic init_wait();
        for (int i = 1; i <= 8; i++) begin
            nxt();
            mem_ready = 1'b0;
            #1;
            chk("init_ready", ready, i == 8);
            if (i == 8) check_grant();
            else        chk("init_no_ack", vid_ack | mem_rd, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        fill_req = 1'b0; fill_we = 1'b0; fill_addr = '0; fill_din = '0; fill_wtbt = 2'b00;
        mem_dout = '0; mem_ready = 1'b0;

        // Reset state with a video request already waiting
        drive_vid(25'h55);
        nxt(); nxt(); #1;
        chk("rst_ready",       ready,       1'b0);
        chk("rst_vid_ack",     vid_ack,     1'b0);
        chk("rst_mem_rd",      mem_rd,      1'b0);
        chk("rst_mem_addr",    mem_addr,    '0);
        chk("rst_mem_wtbt",    mem_wtbt,    2'b00);
        chk("rst_vid_dout",    vid_dout,    '0);
        chk("rst_fill_dout",   fill_dout,   '0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;

        // Init gate, then video read routing of 0x1234
        init_wait();
        complete(1'b0, 1'b0, 3, 16'h1234, 1'b1);

        // Single fill write answered 5 cycles after grant, then a fill read granted the next cycle
        drive_fill(1'b1, 25'h000123, 16'hA5A5, 2'b01);
        #1;
        check_grant();
        complete(1'b1, 1'b1, 5, 16'h0BAD, 1'b1);
        drive_fill(1'b0, 25'h000456, 16'h0000, 2'b11);
        #1;
        check_grant();
        complete(1'b1, 1'b0, 2, 16'h5A5A, 1'b1);

        // Starvation fairness: V,V,V,V,F,V,V,V,V,F
        vid_req = 1'b1; vid_addr = 25'h100;
        fill_req = 1'b1; fill_we = 1'b0; fill_addr = 25'h200; fill_din = '0; fill_wtbt = 2'b11;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) gq.push_back(mk(1'b1, 1'b0, 25'h200, '0, 2'b11));
            else            gq.push_back(mk(1'b0, 1'b0, 25'h100, '0, 2'b11));
        end
        #1;
        for (int k = 0; k < 10; k++) begin
            check_grant();
            complete(k % 5 == 4, 1'b0, 2, 16'(16'h1000 + k), 1'b0);
        end

        // Requests withdrawn before ack are not granted; stray mem_ready in IDLE is ignored
        vid_req = 1'b0; fill_req = 1'b0; mem_ready = 1'b1; mem_dout = 16'hBEEF;
        #1;
        chk("withdraw_vid_ack",  vid_ack,     1'b0);
        chk("withdraw_mem_rd",   mem_rd,      1'b0);
        chk("idle_ready_ignore", vid_valid | fill_valid, 1'b0);
        chk("idle_vid_dout",     vid_dout,    last_vid);
        chk("idle_timeout_err",  timeout_err, 1'b0);

        // Timeout: video grant never answered, pending fill granted right after
        nxt();
        mem_ready = 1'b0;
        drive_vid(25'h77);
        #1;
        check_grant();
        for (int i = 1; i <= 63; i++) begin
            nxt();
            if (i == 1) begin
                vid_req = 1'b0;
                drive_fill(1'b0, 25'h300, 16'h0000, 2'b11);
            end
            #1;
            chk("to_busy_ack",   fill_ack | vid_ack | mem_rd, 1'b0);
            chk("to_busy_valid", vid_valid | fill_valid,     1'b0);
            chk("to_busy_err",   timeout_err,                1'b0);
        end
        nxt(); #1;
        chk("to_err_set",  timeout_err, 1'b1);
        chk("to_no_valid", vid_valid | fill_valid, 1'b0);
        check_grant();

        // Reset two cycles after the grant, late mem_ready afterwards
        nxt(); fill_req = 1'b0; #1;
        chk("mid_busy_rd", mem_rd, 1'b0);
        nxt(); reset = 1'b1; #1;
        chk("mid_rst_ready", ready,      1'b0);
        chk("mid_rst_valid", fill_valid, 1'b0);
        nxt(); reset = 1'b0; mem_ready = 1'b1; mem_dout = 16'hFFFF; #1;
        chk("late_fill_valid", fill_valid,  1'b0);
        chk("late_vid_valid",  vid_valid,   1'b0);
        chk("late_ready",      ready,       1'b0);
        chk("late_err_clear",  timeout_err, 1'b0);
        chk("late_fill_dout",  fill_dout,   '0);
        chk("late_vid_dout",   vid_dout,    '0);
        last_fill = '0;
        last_vid  = '0;
        drive_vid(25'h99);
        init_wait();
        complete(1'b0, 1'b0, 1, 16'h4321, 1'b1);

        chk("grant_queue_drained", gq.size(), 32'd0);
        chk("read_queue_drained",  rq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
